tcp_tx_seg_issue: RTL

- Per-flow transmit segment scheduler that sits directly downstream of the segment-size calculation.
- Owns the flow's next_send_ptr and evaluates the allowed segment size each idle cycle.
- Emits one segment request {ptr, size} at a time to the TX payload/header path over a valid/ready handshake, then advances next_send_ptr.
- Handles retransmit rewind and flow initialisation.

---
 rtl/tcp_tx_pkg.sv | 23 ++
 rtl/seg_size_calc_w_window.sv | 45 ++++
 rtl/tcp_tx_seg_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tcp_tx_pkg.sv
// rtl/tcp_tx_pkg.sv - shared types and pointer helper for the TCP TX segment issue block
package tcp_tx_pkg;

  localparam int TX_PTR_W = 11;

  typedef logic [TX_PTR_W:0] ptr_t;

  typedef struct packed {
    ptr_t ptr;
    ptr_t size;
  } seg_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Pointers carry a wrap bit, so plain subtraction is the distance mod 2^(PTR_W+1)
  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/seg_size_calc_w_window.sv
// rtl/seg_size_calc_w_window.sv - allowed segment size: min(MSS, unsent app data, usable peer window)
module seg_size_calc_w_window
  import tcp_tx_pkg::*;
#(
  parameter int PTR_W        = TX_PTR_W,
  parameter int WIN_SIZE_W   = 16,
  parameter int MAX_SEG_SIZE = 1024
) (
  input  logic [PTR_W:0]      i_trail_ptr,
  input  logic [PTR_W:0]      i_lead_ptr,
  input  logic [PTR_W:0]      i_next_ptr,
  input  logic [WIN_SIZE_W-1:0] i_curr_win,
  output logic [PTR_W:0]      o_seg_size
);

  localparam int CW = ((WIN_SIZE_W > PTR_W + 1) ? WIN_SIZE_W : PTR_W + 1) + 1;

  logic [PTR_W:0] w_avail;
  logic [PTR_W:0] w_in_flight;
  logic [CW-1:0]  w_avail_x;
  logic [CW-1:0]  w_in_flight_x;
  logic [CW-1:0]  w_win_x;
  logic [CW-1:0]  w_usable;
  logic [CW-1:0]  w_mss;
  logic [CW-1:0]  w_min1;
  logic [CW-1:0]  w_min2;
  logic           w_unused_hi;

  assign w_avail       = ptr_diff(i_lead_ptr, i_next_ptr);
  assign w_in_flight   = ptr_diff(i_next_ptr, i_trail_ptr);
  assign w_avail_x     = CW'(w_avail);
  assign w_in_flight_x = CW'(w_in_flight);
  assign w_win_x       = CW'(i_curr_win);
  assign w_mss         = CW'(MAX_SEG_SIZE);

  // trail+win-next clamped at zero, evaluated without wrapping the wide window
  assign w_usable = (w_win_x > w_in_flight_x) ? (w_win_x - w_in_flight_x) : '0;
  assign w_min1   = (w_avail_x < w_mss) ? w_avail_x : w_mss;
  assign w_min2   = (w_usable < w_min1) ? w_usable : w_min1;

  // Result never exceeds w_avail, so the upper bits are always zero
  assign o_seg_size  = w_min2[PTR_W:0];
  assign w_unused_hi = ^w_min2[CW-1:PTR_W+1];

endmodule

// File: rtl/tcp_tx_seg_issue.sv
// rtl/tcp_tx_seg_issue.sv - per-flow TX segment scheduler; optional counters under TCP_TX_SEG_ISSUE_STATS_EN
module tcp_tx_seg_issue
  import tcp_tx_pkg::*;
#(
  parameter int PTR_W        = TX_PTR_W,
  parameter int WIN_SIZE_W   = 16,
  parameter int MAX_SEG_SIZE = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_init_val,
  input  logic [PTR_W:0]        i_init_ptr,
  input  logic [PTR_W:0]        i_trail_ptr,
  input  logic [PTR_W:0]        i_lead_ptr,
  input  logic [WIN_SIZE_W-1:0] i_curr_win,
  input  logic                  i_retx_req,
  output logic                  o_seg_req_val,
  input  logic                  i_seg_req_rdy,
  output logic [PTR_W:0]        o_seg_req_ptr,
  output logic [PTR_W:0]        o_seg_req_size,
  output logic [PTR_W:0]        o_next_send_ptr,
`ifdef TCP_TX_SEG_ISSUE_STATS_EN
  output logic [31:0]           o_stat_segs_sent,
  output logic [15:0]           o_stat_retx_cnt,
`endif
  output logic                  o_data_in_flight
);

  state_t   r_state, w_state_nxt;
  ptr_t     r_next, w_next_nxt;
  seg_req_t r_req, w_req_nxt;
  logic     r_pend, w_pend_nxt;
  ptr_t     w_seg_calc;

  seg_size_calc_w_window #(
    .PTR_W       (PTR_W),
    .WIN_SIZE_W  (WIN_SIZE_W),
    .MAX_SEG_SIZE(MAX_SEG_SIZE)
  ) u_calc (
    .i_trail_ptr(i_trail_ptr),
    .i_lead_ptr (i_lead_ptr),
    .i_next_ptr (r_next),
    .i_curr_win (i_curr_win),
    .o_seg_size (w_seg_calc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_next  <= '0;
      r_req   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_next  <= w_next_nxt;
      r_req   <= w_req_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_next_nxt  = r_next;
    w_req_nxt   = r_req;
    w_pend_nxt  = r_pend;
    if (i_init_val) begin
      w_state_nxt = ST_IDLE;
      w_next_nxt  = i_init_ptr;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_retx_req || r_pend) begin
            w_next_nxt = i_trail_ptr;
            w_pend_nxt = 1'b0;
          end else if (ptr_diff(r_next, i_trail_ptr) > ptr_diff(i_lead_ptr, i_trail_ptr)) begin
            // ACK moved past next_send_ptr: snap forward to the new trail
            w_next_nxt = i_trail_ptr;
          end else if (w_seg_calc != '0) begin
            w_req_nxt.ptr  = r_next;
            w_req_nxt.size = w_seg_calc;
            w_state_nxt    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_retx_req) begin
            w_pend_nxt = 1'b1;
          end
          if (i_seg_req_rdy) begin
            w_next_nxt  = r_req.ptr + r_req.size;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_seg_req_val    = (r_state == ST_ISSUE);
  assign o_seg_req_ptr    = r_req.ptr;
  assign o_seg_req_size   = r_req.size;
  assign o_next_send_ptr  = r_next;
  assign o_data_in_flight = (r_next != i_trail_ptr);

`ifdef TCP_TX_SEG_ISSUE_STATS_EN
  logic        w_hs;
  logic        w_rew;
  logic [31:0] r_segs_sent;
  logic [15:0] r_retx_cnt;

  assign w_hs  = !i_init_val && (r_state == ST_ISSUE) && i_seg_req_rdy;
  assign w_rew = !i_init_val && (r_state == ST_IDLE) && (i_retx_req || r_pend);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_segs_sent <= '0;
      r_retx_cnt  <= '0;
    end else begin
      if (w_hs && (r_segs_sent != '1)) r_segs_sent <= r_segs_sent + 32'd1;
      if (w_rew && (r_retx_cnt != '1)) r_retx_cnt <= r_retx_cnt + 16'd1;
    end
  end

  assign o_stat_segs_sent = r_segs_sent;
  assign o_stat_retx_cnt  = r_retx_cnt;
`endif

endmodule
